// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard unit and the datapath.
// The master drives hazard inputs; the slave (hazard_ctrl) drives latch controls.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             ex_dREN;
  logic             ex_regWr;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             ex_redirect;
  logic             wb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN,
    output ex_dREN, ex_regWr, ex_rd,
    output id_rs1, id_rs2, id_uses_rs2,
    output ex_redirect, wb_halt,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_en, idex_flush,
    input  exmem_en, exmem_flush,
    input  memwb_en, memwb_flush,
    input  halt_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN,
    input  ex_dREN, ex_regWr, ex_rd,
    input  id_rs1, id_rs2, id_uses_rs2,
    input  ex_redirect, wb_halt,
    output pc_en, ifid_en, ifid_flush,
    output idex_en, idex_flush,
    output exmem_en, exmem_flush,
    output memwb_en, memwb_flush,
    output halt_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush control for the 5-stage core: memory wait,
// load-use, EX redirect, fetch miss and halt, plus perf counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic          CLK,
  input logic          RST,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALTED
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_busy;
  logic w_rd_match;
  logic w_load_use;
  logic w_halted;
  logic w_redirect_taken;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_en;
  logic w_idex_flush;
  logic w_exmem_en;
  logic w_exmem_flush;
  logic w_memwb_en;
  logic w_memwb_flush;
  logic w_stall_sat;
  logic w_flush_sat;

  always_comb begin
    w_mem_busy = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
    w_rd_match = (bus.ex_rd == bus.id_rs1)
               | (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2));
    w_load_use = bus.ex_dREN & bus.ex_regWr
               & (bus.ex_rd != 5'd0) & w_rd_match;
    w_halted   = (r_state == HALTED);
  end

  // Priority decode; every arm leaves en and flush mutually exclusive.
  always_comb begin
    w_pc_en          = 1'b0;
    w_ifid_en        = 1'b0;
    w_ifid_flush     = 1'b0;
    w_idex_en        = 1'b0;
    w_idex_flush     = 1'b0;
    w_exmem_en       = 1'b0;
    w_exmem_flush    = 1'b0;
    w_memwb_en       = 1'b0;
    w_memwb_flush    = 1'b0;
    w_redirect_taken = 1'b0;
    priority case (1'b1)
      RST: begin
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_flush = 1'b1;
        w_memwb_flush = 1'b1;
      end
      w_halted: begin
      end
      w_mem_busy: begin
        w_memwb_flush = 1'b1;
      end
      bus.ex_redirect: begin
        w_pc_en          = 1'b1;
        w_ifid_flush     = 1'b1;
        w_idex_flush     = 1'b1;
        w_exmem_en       = 1'b1;
        w_memwb_en       = 1'b1;
        w_redirect_taken = 1'b1;
      end
      w_load_use: begin
        w_idex_flush = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
      end
      ~bus.ihit: begin
        w_ifid_flush = 1'b1;
        w_idex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
      end
      default: begin
        w_pc_en    = 1'b1;
        w_ifid_en  = 1'b1;
        w_idex_en  = 1'b1;
        w_exmem_en = 1'b1;
        w_memwb_en = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (bus.wb_halt & w_memwb_en)
          w_state_nxt = HALTED;
        else if (w_mem_busy)
          w_state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.wb_halt & w_memwb_en)
          w_state_nxt = HALTED;
        else if (~w_mem_busy)
          w_state_nxt = RUN;
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    w_stall_sat = &r_stall_cnt;
    w_flush_sat = &r_flush_cnt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_halt  <= r_halt | (w_state_nxt == HALTED);
      if (~w_halted & ~w_pc_en & ~w_stall_sat)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect_taken & ~w_flush_sat)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.pc_en       = w_pc_en;
    bus.ifid_en     = w_ifid_en;
    bus.ifid_flush  = w_ifid_flush;
    bus.idex_en     = w_idex_en;
    bus.idex_flush  = w_idex_flush;
    bus.exmem_en    = w_exmem_en;
    bus.exmem_flush = w_exmem_flush;
    bus.memwb_en    = w_memwb_en;
    bus.memwb_flush = w_memwb_flush;
    bus.halt_o      = r_halt;
    bus.stall_cnt   = r_stall_cnt;
    bus.flush_cnt   = r_flush_cnt;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random
// traffic, checked against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       mdr;
    logic       mdw;
    logic       exdr;
    logic       exwr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic       redir;
    logic       halt;
  } stim_t;

  typedef struct packed {
    logic [8:0]   ctl;
    logic         halt;
    logic [W-1:0] sc;
    logic [W-1:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if #(.CNT_W(W)) bus ();

  hazard_ctrl #(.CNT_W(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   m_halt = 1'b0;
  int   m_sc   = 0;
  int   m_fc   = 0;
  bit   drv_done = 1'b0;

  // Control word: {pc, ifid_en, ifid_fl, idex_en, idex_fl,
  //                exmem_en, exmem_fl, memwb_en, memwb_fl}
  function automatic logic [8:0] ref_ctl(input stim_t s,
                                         input bit halted,
                                         output bit redir_taken);
    bit busy;
    bit lu;
    redir_taken = 1'b0;
    busy = (s.mdr || s.mdw) && !s.dhit;
    lu = s.exdr && s.exwr && s.rd != 0 &&
         (s.rd == s.rs1 || (s.uses2 && s.rd == s.rs2));
    if (s.rst)      return 9'b001010101;
    if (halted)     return 9'b000000000;
    if (busy)       return 9'b000000001;
    if (s.redir) begin
      redir_taken = 1'b1;
      return 9'b101011010;
    end
    if (lu)         return 9'b000011010;
    if (!s.ihit)    return 9'b001101010;
    return 9'b110101010;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    s.rd = 5'd7;
    s.rs1 = 5'd1;
    s.rs2 = 5'd2;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst             = s.rst;
    bus.ihit        = s.ihit;
    bus.dhit        = s.dhit;
    bus.mem_dREN    = s.mdr;
    bus.mem_dWEN    = s.mdw;
    bus.ex_dREN     = s.exdr;
    bus.ex_regWr    = s.exwr;
    bus.ex_rd       = s.rd;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_uses_rs2 = s.uses2;
    bus.ex_redirect = s.redir;
    bus.wb_halt     = s.halt;
  endtask

  task automatic apply(input stim_t s);
    exp_t       e;
    bit         rt;
    logic [8:0] c;
    @(posedge clk);
    #1;
    drive(s);
    c = ref_ctl(s, m_halt, rt);
    e.ctl  = c;
    e.halt = m_halt;
    e.sc   = W'(m_sc);
    e.fc   = W'(m_fc);
    exp_q.push_back(e);
    if (s.rst) begin
      m_halt = 1'b0;
      m_sc   = 0;
      m_fc   = 0;
    end else if (!m_halt) begin
      if (s.halt && c[1]) m_halt = 1'b1;
      if (!c[8] && m_sc < MAX) m_sc++;
      if (rt && m_fc < MAX) m_fc++;
    end
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rst   = ($urandom_range(99) < 2);
    s.ihit  = ($urandom_range(99) < 85);
    s.dhit  = $urandom_range(1);
    s.mdr   = ($urandom_range(99) < 25);
    s.mdw   = ($urandom_range(99) < 15);
    s.exdr  = ($urandom_range(99) < 40);
    s.exwr  = ($urandom_range(99) < 75);
    s.rd    = 5'($urandom_range(3));
    s.rs1   = 5'($urandom_range(3));
    s.rs2   = 5'($urandom_range(3));
    s.uses2 = $urandom_range(1);
    s.redir = ($urandom_range(99) < 15);
    s.halt  = ($urandom_range(99) < 3);
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.ctl  = {bus.pc_en, bus.ifid_en, bus.ifid_flush,
                bus.idex_en, bus.idex_flush,
                bus.exmem_en, bus.exmem_flush,
                bus.memwb_en, bus.memwb_flush};
      a.halt = bus.halt_o;
      a.sc   = bus.stall_cnt;
      a.fc   = bus.flush_cnt;
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL vec%0d t=%0t ctl=%b/%b halt=%b/%b stall=%0d/%0d flush=%0d/%0d (got/expected)",
                 n_vec, $time, a.ctl, e.ctl, a.halt, e.halt,
                 a.sc, e.sc, a.fc, e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    apply(s);
    for (int i = 0; i < 10; i++) apply(idle());
    s = idle();
    s.exdr = 1; s.exwr = 1; s.rd = 5; s.rs1 = 5;
    apply(s);
    apply(idle());
    s.rd = 0; s.rs1 = 0;
    apply(s);
    s = idle();
    s.mdr = 1;
    for (int i = 0; i < 3; i++) apply(s);
    s.dhit = 1;
    apply(s);
    s = idle();
    s.mdw = 1; s.redir = 1;
    for (int i = 0; i < 2; i++) apply(s);
    s.dhit = 1;
    apply(s);
    apply(idle());
    s = idle();
    s.halt = 1;
    apply(s);
    for (int i = 0; i < 20; i++) apply(rnd() & ~stim_t'(1) << 0 | stim_t'(0));
    s = idle();
    s.rst = 1;
    apply(s);
    s = idle();
    s.ihit = 0;
    for (int i = 0; i < 20; i++) apply(s);
    for (int i = 0; i < 2000; i++) apply(rnd());
    drv_done = 1'b1;
  end

  initial begin
    int guard;
    wait (drv_done);
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control unit for the 5-stage core. It drives the enable/flush pairs consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
- It resolves data-memory wait, load-use, EX-stage redirect, instruction-fetch miss and halt.
- Registered state: a wait/halt FSM, a sticky halt flag, and saturating stall and flush performance counters.
- Latches give flush priority over enable. This block never asserts both en and flush for the same latch in one cycle.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction memory returned data this cycle
dhit  in  1  data memory completed request this cycle
mem_dREN  in  1  instruction in MEM is a load
mem_dWEN  in  1  instruction in MEM is a store
ex_dREN  in  1  instruction in EX is a load
ex_regWr  in  1  instruction in EX writes the register file
ex_rd  in  5  destination register of the EX instruction
id_rs1  in  5  source register 1 of the ID instruction
id_rs2  in  5  source register 2 of the ID instruction
id_uses_rs2  in  1  ID instruction reads rs2
ex_redirect  in  1  branch taken or jump resolved in EX
wb_halt  in  1  halt instruction reaching WB
pc_en  out  1  PC register load enable
ifid_en, ifid_flush  out  1 each  IF/ID latch controls
idex_en, idex_flush  out  1 each  ID/EX latch controls
exmem_en, exmem_flush  out  1 each  EX/MEM latch controls
memwb_en, memwb_flush  out  1 each  MEM/WB latch controls
halt_o  out  1  core halted, sticky
stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
flush_cnt  out  CNT_W  redirects applied

Behaviour:
- Reset (RST=1 at clock edge):
  - state=RUN, halt_o=0, counters=0.
  - While RST=1, all en=0 and all flush=1, so a reset-time edge loads bubbles.
  - Reset mid-stall or while HALTED returns to RUN the next cycle.
- Derived signals:
  - mem_busy = (mem_dREN|mem_dWEN) & ~dhit.
  - load_use = ex_dREN & ex_regWr & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- FSM states: RUN, MEM_WAIT, HALTED.
  - RUN -> MEM_WAIT when mem_busy.
  - MEM_WAIT -> RUN on dhit.
  - any -> HALTED when wb_halt=1 and the MEM/WB latch is enabled that cycle.
  - HALTED -> HALTED until RST.
- Output decode is combinational from state and inputs, in priority order:
  - HALTED: all en=0, all flush=0, pc_en=0, halt_o=1. Counters frozen.
  - mem_busy (RUN or MEM_WAIT): pc_en=0; ifid, idex, exmem en=0; memwb_en=0, memwb_flush=1 (bubble into WB, no double commit). ex_redirect is ignored; EX is frozen, so the redirect is re-presented after release.
  - ex_redirect: pc_en=1 (PC loads target regardless of ihit; in-flight fetch discarded); ifid_flush=1, idex_flush=1; exmem_en=1, memwb_en=1. flush_cnt+1.
  - load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. Exactly one bubble, because the load moves to MEM the next cycle.
  - ~ihit: pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1, memwb_en=1. Downstream drains.
  - otherwise: pc_en=1 and all en=1, all flush=0.
- dhit in the same cycle as mem request: no stall.
- mem_busy and load_use together: mem_busy wins. Load-use is re-evaluated after release.
- stall_cnt increments when state!=HALTED and pc_en=0; it saturates at 2^CNT_W-1. flush_cnt saturates the same way.
- wb_halt while mem_busy: memwb_en=0, so the halt does not enter HALTED until WB advances.

Test Plan:
1. Steady state: ihit=1, no hazards for 10 cycles -> pc_en=1 and all en=1 every cycle; stall_cnt=0.
2. Load-use: ex_dREN=1, ex_regWr=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 for that cycle only; stall_cnt=1. Same with ex_rd=0 -> no stall.
3. Memory wait: mem_dREN=1, dhit low for 3 cycles then high -> state MEM_WAIT for 3 cycles, memwb_flush=1 for 3 cycles, full advance on the dhit cycle; stall_cnt=3.
4. Redirect during mem wait: ex_redirect=1 with mem_busy for 2 cycles, then dhit -> no flushes during the wait; ifid_flush=idex_flush=1 on the release cycle; flush_cnt=1.
5. Halt: wb_halt=1 with full advance -> halt_o=1 next cycle, all en=0; stays halted for 20 cycles; RST=1 for one edge -> RUN, halt_o=0, counters=0.
6. Saturation: with CNT_W=4, hold ihit=0 for 20 cycles -> stall_cnt=15 and stays 15.
